// File: rtl/frontend_source_ctrl.sv
// Front-end source sequencer: tracks per-source PCM activity, picks a target
// source (auto priority or manual) and wraps every input_sel change in a
// mute -> switch -> settle sequence so the downstream path never clicks.
//
//   state  | meaning
//   RUN    | locked on sel_out, audio passes (mute=0)
//   MUTE   | output muted, counting down before sel_out is allowed to move
//   SETTLE | sel_out applied, muted until enough frames arrive from it
module frontend_source_ctrl #(
    parameter int TIMEOUT       = 4096,
    parameter int MUTE_CYCLES   = 64,
    parameter int SETTLE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto_en,
    input  logic [1:0] manual_sel,
    input  logic [3:0] src_valid,
    output logic [1:0] sel_out,
    output logic       mute,
    output logic       busy,
    output logic [3:0] src_active,
    output logic       no_signal
);

    localparam int ACT_W  = $clog2(TIMEOUT + 1);
    localparam int MUTE_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam int FRM_W  = $clog2(SETTLE_FRAMES + 1);

    localparam logic [ACT_W-1:0]  ACT_MAX   = ACT_W'(TIMEOUT);
    localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYCLES - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MUTE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACT_W-1:0]   r_act_cnt [4];
    logic [3:0]         r_src_active;
    logic [MUTE_W-1:0]  r_mute_cnt;
    logic [FRM_W-1:0]   r_frm_cnt;
    logic [1:0]         r_sel;
    logic [1:0]         w_target;
    logic               w_retarget;
    logic               w_frame_hit;
    logic               w_frames_done;

    // Per-source activity: a strobe restarts the idle timer and wins over expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_act_cnt[i] <= ACT_MAX;
            end
            r_src_active <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (src_valid[i]) begin
                    r_act_cnt[i]    <= '0;
                    r_src_active[i] <= 1'b1;
                end else if (r_act_cnt[i] != ACT_MAX) begin
                    r_act_cnt[i] <= r_act_cnt[i] + 1'b1;
                    if (r_act_cnt[i] == ACT_MAX - 1'b1) begin
                        r_src_active[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Target selection: priority 1,2,3,0 in auto mode, hold when nothing is live.
    always_comb begin
        w_target = r_sel;
        if (auto_en) begin
            if (r_src_active[1])      w_target = 2'd1;
            else if (r_src_active[2]) w_target = 2'd2;
            else if (r_src_active[3]) w_target = 2'd3;
            else if (r_src_active[0]) w_target = 2'd0;
        end else begin
            w_target = manual_sel;
        end
    end

    assign w_retarget    = (w_target != r_sel);
    assign w_frame_hit   = src_valid[r_sel];
    assign w_frames_done = w_frame_hit && (r_frm_cnt == FRM_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_SETTLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a retarget during SETTLE forces a fresh full mute.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_retarget) w_state_nxt = ST_MUTE;
            ST_MUTE:   if (r_mute_cnt == '0) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (w_retarget)         w_state_nxt = ST_MUTE;
                else if (w_frames_done) w_state_nxt = ST_RUN;
            end
            default:   w_state_nxt = ST_SETTLE;
        endcase
    end

    // Mute/frame counters and sel_out; sel_out only moves on MUTE -> SETTLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel      <= 2'd0;
            r_mute_cnt <= '0;
            r_frm_cnt  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_retarget) r_mute_cnt <= MUTE_LOAD;
                end
                ST_MUTE: begin
                    if (r_mute_cnt == '0) begin
                        r_sel     <= w_target;
                        r_frm_cnt <= '0;
                    end else begin
                        r_mute_cnt <= r_mute_cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_retarget)       r_mute_cnt <= MUTE_LOAD;
                    else if (w_frame_hit) r_frm_cnt  <= r_frm_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: muted and busy whenever not locked in RUN.
    always_comb begin
        mute      = (r_state != ST_RUN);
        busy      = (r_state != ST_RUN);
        no_signal = (r_src_active == 4'b0000);
    end

    assign sel_out    = r_sel;
    assign src_active = r_src_active;

endmodule

// File: tb/tb_frontend_source_ctrl.sv
// Bench for frontend_source_ctrl: directed scenarios plus random traffic,
// all checked every cycle against an event-time reference model.
module tb_frontend_source_ctrl;

    localparam int TO = 64;
    localparam int MC = 8;
    localparam int SF = 2;
    localparam int PH_RUN    = 0;
    localparam int PH_MUTE   = 1;
    localparam int PH_SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] manual_sel = 2'd0;
    logic [3:0] src_valid = 4'd0;
    logic [1:0] sel_out;
    logic       mute;
    logic       busy;
    logic [3:0] src_active;
    logic       no_signal;

    int checks = 0;
    int failures = 0;

    // Reference model: activity from the edge index of the last strobe,
    // sequencing from the absolute edge at which the switch is due.
    int         m_n = 0;
    int         m_last [4] = '{-1000000, -1000000, -1000000, -1000000};
    int         m_phase = PH_SETTLE;
    logic [1:0] m_sel = 2'd0;
    int         m_switch_at = 0;
    int         m_frames = 0;
    logic [1:0] prev_sel = 2'bxx;
    logic       prev_mute = 1'bx;

    frontend_source_ctrl #(
        .TIMEOUT(TO), .MUTE_CYCLES(MC), .SETTLE_FRAMES(SF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .manual_sel(manual_sel),
        .src_valid(src_valid), .sel_out(sel_out), .mute(mute), .busy(busy),
        .src_active(src_active), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_active();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = ((m_n - m_last[i]) < TO);
        return a;
    endfunction

    function automatic logic [1:0] m_target(input logic [3:0] act);
        int order [4];
        order = '{1, 2, 3, 0};
        if (!auto_en) return manual_sel;
        for (int k = 0; k < 4; k++) begin
            if (act[order[k]]) return 2'(order[k]);
        end
        return m_sel;
    endfunction

    // One clock: advance the model with the pre-edge inputs, then compare.
    task automatic step();
        logic [3:0] act;
        logic [1:0] tgt;
        logic       rst_at_edge;
        @(posedge clk);
        act = m_active();
        tgt = m_target(act);
        rst_at_edge = rst_n;
        m_n++;
        if (!rst_n) begin
            m_phase = PH_SETTLE;
            m_sel = 2'd0;
            m_frames = 0;
            for (int i = 0; i < 4; i++) m_last[i] = -1000000;
        end else begin
            case (m_phase)
                PH_RUN: if (tgt != m_sel) begin
                    m_phase = PH_MUTE;
                    m_switch_at = m_n + MC;
                end
                PH_MUTE: if (m_n == m_switch_at) begin
                    m_sel = tgt;
                    m_frames = 0;
                    m_phase = PH_SETTLE;
                end
                default: begin
                    if (tgt != m_sel) begin
                        m_phase = PH_MUTE;
                        m_switch_at = m_n + MC;
                    end else if (src_valid[m_sel]) begin
                        m_frames++;
                        if (m_frames == SF) m_phase = PH_RUN;
                    end
                end
            endcase
            for (int i = 0; i < 4; i++) if (src_valid[i]) m_last[i] = m_n;
        end
        #1;
        checks++;
        if (sel_out !== m_sel) begin
            failures++;
            $display("FAIL model_sel edge=%0d got=%0d exp=%0d", m_n, sel_out, m_sel);
        end
        checks++;
        if (mute !== (m_phase != PH_RUN)) begin
            failures++;
            $display("FAIL model_mute edge=%0d got=%0b exp=%0b", m_n, mute, m_phase != PH_RUN);
        end
        checks++;
        if (busy !== (m_phase != PH_RUN)) begin
            failures++;
            $display("FAIL model_busy edge=%0d got=%0b exp=%0b", m_n, busy, m_phase != PH_RUN);
        end
        checks++;
        if (src_active !== m_active()) begin
            failures++;
            $display("FAIL model_active edge=%0d got=%b exp=%b", m_n, src_active, m_active());
        end
        checks++;
        if (no_signal !== (m_active() == 4'b0)) begin
            failures++;
            $display("FAIL model_nosig edge=%0d got=%0b exp=%0b", m_n, no_signal, m_active() == 4'b0);
        end
        if (rst_at_edge && prev_sel !== 2'bxx && sel_out !== prev_sel) begin
            checks++;
            if (!(mute === 1'b1 && prev_mute === 1'b1)) begin
                failures++;
                $display("FAIL sel_change_muted edge=%0d mute_before=%0b mute_after=%0b exp=1/1",
                         m_n, prev_mute, mute);
            end
        end
        prev_sel = sel_out;
        prev_mute = mute;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; auto_en = 1'b0; manual_sel = 2'd0; src_valid = 4'd0;
        repeat (3) step();
        checks++;
        if (sel_out !== 2'd0 || mute !== 1'b1 || busy !== 1'b1 || src_active !== 4'd0 || no_signal !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got sel=%0d mute=%0b busy=%0b act=%b nosig=%0b exp 0/1/1/0000/1",
                     sel_out, mute, busy, src_active, no_signal);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_manual_settle();
        repeat (3) step();
        checks++;
        if (mute !== 1'b1) begin failures++; $display("FAIL settle_idle mute got=%0b exp=1", mute); end
        src_valid = 4'b0001; step(); src_valid = 4'd0;
        checks++;
        if (mute !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL settle_one_frame mute=%0b busy=%0b exp=1/1", mute, busy);
        end
        repeat (3) step();
        src_valid = 4'b0001; step(); src_valid = 4'd0;
        checks++;
        if (mute !== 1'b0 || busy !== 1'b0 || sel_out !== 2'd0) begin
            failures++; $display("FAIL settle_two_frames mute=%0b busy=%0b sel=%0d exp=0/0/0", mute, busy, sel_out);
        end
    endtask

    task automatic test_auto_switch();
        int act_e, mute_e, sel_e, unmute_e;
        act_e = -1; mute_e = -1; sel_e = -1; unmute_e = -1;
        auto_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            src_valid = (k % 20 == 0) ? 4'b0010 : 4'b0000;
            step();
            if (act_e < 0 && src_active[1] === 1'b1) act_e = k;
            if (mute_e < 0 && mute === 1'b1) mute_e = k;
            if (sel_e < 0 && sel_out === 2'd1) sel_e = k;
            if (sel_e >= 0 && unmute_e < 0 && mute === 1'b0) unmute_e = k;
        end
        src_valid = 4'd0;
        checks++;
        if (act_e != 0)  begin failures++; $display("FAIL auto_active_edge got=%0d exp=0", act_e); end
        checks++;
        if (mute_e != 1) begin failures++; $display("FAIL auto_mute_edge got=%0d exp=1", mute_e); end
        checks++;
        if (sel_e != 9)  begin failures++; $display("FAIL auto_sel_edge got=%0d exp=9", sel_e); end
        checks++;
        if (unmute_e != 40) begin failures++; $display("FAIL auto_unmute_edge got=%0d exp=40", unmute_e); end
    endtask

    task automatic test_failover();
        int clr_e, sel_e, unmute_e, nosig_e;
        clr_e = -1; sel_e = -1; unmute_e = -1; nosig_e = -1;
        for (int k = 0; k < 300; k++) begin
            if (k < 100 && k % 20 == 0)       src_valid = 4'b0110;
            else if (k < 200 && k % 20 == 0)  src_valid = 4'b0100;
            else                              src_valid = 4'b0000;
            step();
            if (clr_e < 0 && src_active[1] === 1'b0) clr_e = k;
            if (sel_e < 0 && sel_out === 2'd2) sel_e = k;
            if (sel_e >= 0 && unmute_e < 0 && mute === 1'b0) unmute_e = k;
            if (nosig_e < 0 && no_signal === 1'b1) nosig_e = k;
        end
        src_valid = 4'd0;
        checks++;
        if (clr_e != 144) begin failures++; $display("FAIL failover_clear_edge got=%0d exp=144", clr_e); end
        checks++;
        if (sel_e != 153) begin failures++; $display("FAIL failover_sel_edge got=%0d exp=153", sel_e); end
        checks++;
        if (unmute_e != 180) begin failures++; $display("FAIL failover_unmute_edge got=%0d exp=180", unmute_e); end
        checks++;
        if (nosig_e != 244) begin failures++; $display("FAIL failover_nosig_edge got=%0d exp=244", nosig_e); end
        checks++;
        if (sel_out !== 2'd2 || mute !== 1'b0) begin
            failures++; $display("FAIL failover_hold sel=%0d mute=%0b exp=2/0", sel_out, mute);
        end
    endtask

    task automatic test_manual_redirect();
        int  n;
        logic saw3;
        auto_en = 1'b0; manual_sel = 2'd0;
        n = 0;
        step();
        while (mute !== 1'b0 && n < 60) begin
            src_valid = (n % 5 == 0) ? 4'b0001 : 4'b0000;
            step();
            n++;
        end
        src_valid = 4'd0;
        checks++;
        if (mute !== 1'b0 || sel_out !== 2'd0) begin
            failures++; $display("FAIL redirect_setup_timeout mute=%0b sel=%0d exp=0/0", mute, sel_out);
        end
        saw3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            manual_sel = (k < 4) ? 2'd3 : 2'd2;
            step();
            if (sel_out === 2'd3) saw3 = 1'b1;
            if (k == 0) begin
                checks++;
                if (mute !== 1'b1) begin failures++; $display("FAIL redirect_mute_rise got=%0b exp=1", mute); end
            end
            if (k == 7) begin
                checks++;
                if (sel_out !== 2'd0) begin failures++; $display("FAIL redirect_pre_switch got=%0d exp=0", sel_out); end
            end
            if (k == 8) begin
                checks++;
                if (sel_out !== 2'd2) begin failures++; $display("FAIL redirect_switch got=%0d exp=2", sel_out); end
            end
        end
        checks++;
        if (saw3) begin failures++; $display("FAIL redirect_never3 got=3 exp=not 3"); end
    endtask

    task automatic test_settle_redirect();
        manual_sel = 2'd3;
        repeat (9) step();
        checks++;
        if (sel_out !== 2'd3 || mute !== 1'b1) begin
            failures++; $display("FAIL resettle_on3 sel=%0d mute=%0b exp=3/1", sel_out, mute);
        end
        src_valid = 4'b1000; step(); src_valid = 4'd0;
        manual_sel = 2'd1;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (mute !== 1'b1 || sel_out !== ((k < 8) ? 2'd3 : 2'd1)) begin
                failures++;
                $display("FAIL resettle_mute k=%0d sel=%0d mute=%0b exp=%0d/1", k, sel_out, mute, (k < 8) ? 3 : 1);
            end
        end
        src_valid = 4'b0010; step(); src_valid = 4'd0;
        checks++;
        if (mute !== 1'b1) begin failures++; $display("FAIL resettle_no_carry mute=%0b exp=1", mute); end
        step();
        src_valid = 4'b0010; step(); src_valid = 4'd0;
        checks++;
        if (mute !== 1'b0 || sel_out !== 2'd1) begin
            failures++; $display("FAIL resettle_done mute=%0b sel=%0d exp=0/1", mute, sel_out);
        end
    endtask

    task automatic test_reset_mid_mute();
        manual_sel = 2'd2;
        repeat (4) step();
        rst_n = 1'b0; src_valid = 4'hF;
        step();
        checks++;
        if (sel_out !== 2'd0 || mute !== 1'b1 || busy !== 1'b1 || src_active !== 4'd0 || no_signal !== 1'b1) begin
            failures++;
            $display("FAIL midreset got sel=%0d mute=%0b busy=%0b act=%b nosig=%0b exp 0/1/1/0000/1",
                     sel_out, mute, busy, src_active, no_signal);
        end
        rst_n = 1'b1; src_valid = 4'd0;
        step();
        checks++;
        if (src_active !== 4'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL midreset_after act=%b busy=%0b exp=0000/1", src_active, busy);
        end
    endtask

    task automatic test_random();
        int rate [4];
        logic [3:0] mask;
        rate = '{10, 25, 40, 90};
        mask = 4'hF;
        for (int k = 0; k < 3000; k++) begin
            if (k % 400 == 0) mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 63) == 0) manual_sel = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++)
                src_valid[i] = mask[i] && ($urandom_range(0, rate[i]) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n = 1'b1; src_valid = 4'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_manual_settle();
        test_auto_switch();
        test_failover();
        test_manual_redirect();
        test_settle_redirect();
        test_reset_mid_mute();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
